// File: rtl/counter_mod_k_updown_pkg.sv
// counter_pkg: shared direction type and effective-modulus helper for the mod-k counter
package counter_pkg;

    localparam int N_MAX = 32;

    typedef enum logic {DIR_DOWN, DIR_UP} dir_t;

    // A programmed modulus of 0 stands for 2**n, so the result needs one extra bit
    function automatic logic [N_MAX:0] k_eff(input logic [N_MAX-1:0] k, input int unsigned n);
        return (k == '0) ? ((N_MAX+1)'(1) << n) : {1'b0, k};
    endfunction

endpackage

// File: rtl/counter_mod_k_updown_if.sv
// counter_mod_k_updown_if: control and status bundle of the mod-k up/down counter
interface counter_mod_k_updown_if #(parameter int N = 4);

    logic         i_en;
    logic         i_up;
    logic [N-1:0] i_k;
    logic         i_load;
    logic [N-1:0] i_load_val;
    logic [N-1:0] o_count;
    logic [N-1:0] o_k_active;
    logic         o_roll_over;

    modport master (
        output i_en, i_up, i_k, i_load, i_load_val,
        input  o_count, o_k_active, o_roll_over
    );

    modport slave (
        input  i_en, i_up, i_k, i_load, i_load_val,
        output o_count, o_k_active, o_roll_over
    );

endinterface

// File: rtl/counter_mod_k_updown_term_detect.sv
// counter_term_detect: terminal-count detection and wrap target for the mod-k counter
module counter_term_detect
    import counter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] count_i,
    input  logic [N-1:0] k_act_i,
    input  logic [N-1:0] k_next_i,
    input  dir_t         dir_i,
    output logic         at_term_o,
    output logic [N-1:0] wrap_val_o
);

    logic [N:0] keff_act;
    logic [N:0] keff_next;

    // Terminal uses the modulus in force; the wrap target already uses the requested one
    always_comb begin
        keff_act   = (N+1)'(k_eff(N_MAX'(k_act_i), N));
        keff_next  = (N+1)'(k_eff(N_MAX'(k_next_i), N));
        at_term_o  = count_i == ((dir_i == DIR_UP) ? N'(keff_act - 1'b1) : '0);
        wrap_val_o = (dir_i == DIR_UP) ? '0 : N'(keff_next - 1'b1);
    end

endmodule

// File: rtl/counter_mod_k_updown.sv
// counter_mod_k_updown: up/down counter modulo a shadowed runtime k with load and cascade carry
module counter_mod_k_updown
    import counter_pkg::*;
#(
    parameter int N     = 4,
    parameter int K_DEF = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    counter_mod_k_updown_if.slave  bus
);

    logic [N-1:0] count_q, count_d;
    logic [N-1:0] k_act_q, k_act_d;
    logic [N:0]   keff_req;
    logic [N-1:0] load_cnt;
    logic [N-1:0] wrap_val;
    logic         at_term;
    dir_t         dir;

    assign dir = dir_t'(bus.i_up);

    counter_term_detect #(.N(N)) u_term (
        .count_i    (count_q),
        .k_act_i    (k_act_q),
        .k_next_i   (bus.i_k),
        .dir_i      (dir),
        .at_term_o  (at_term),
        .wrap_val_o (wrap_val)
    );

    // Priority load > enable > hold; k_act only picks up i_k on a load or a wrap
    always_comb begin
        keff_req = (N+1)'(k_eff(N_MAX'(bus.i_k), N));
        load_cnt = ({1'b0, bus.i_load_val} < keff_req) ? bus.i_load_val : N'(keff_req - 1'b1);
        count_d  = bus.i_load ? load_cnt :
                   !bus.i_en  ? count_q  :
                   at_term    ? wrap_val :
                   (dir == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
        k_act_d  = (bus.i_load || (bus.i_en && at_term)) ? bus.i_k : k_act_q;
    end

    // Count and active-modulus registers, async reset to the default modulus
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
            k_act_q <= N'(K_DEF);
        end else begin
            count_q <= count_d;
            k_act_q <= k_act_d;
        end
    end

    assign bus.o_count     = count_q;
    assign bus.o_k_active  = k_act_q;
    assign bus.o_roll_over = bus.i_en & ~bus.i_load & at_term;

endmodule
